// File: rtl/io_peripheral_responder.sv
// ----------------------------------------------------------------------------
// io_peripheral_responder
//   Peripheral-side end of the CPU IO bus. Answers the LED and switch chip
//   selects with ioRead/ioWrite strobes, holds the 24 LED output registers,
//   debounces the 24 board switches and returns 16-bit read data, including a
//   read-to-clear "switches changed" flag.
//
//   Register map (addr[3:0]):
//     LEDCtrl    0x0  led[15:0]            R/W
//                0x2  led[23:16]           R/W (read zero-extended)
//     SwitchCtrl 0x0  sw_db[15:0]          R
//                0x2  sw_db[23:16]         R   (zero-extended)
//                0x4  {15'b0, chg}         R   (read-to-clear)
//     other addresses read 0, writes ignored.
//
// Ports
//   clock       in   1   system clock, all state on rising edge
//   reset       in   1   synchronous, active-high
//   ioRead      in   1   CPU IO read strobe
//   ioWrite     in   1   CPU IO write strobe
//   LEDCtrl     in   1   LED chip select (wins if both selects are high)
//   SwitchCtrl  in   1   switch chip select
//   addr        in   4   IO address bits [3:0]
//   write_data  in  16   write data
//   switch_in   in  24   raw asynchronous switch pins
//   io_rdata    out 16   combinational read data
//   led         out 24   registered LED drive
// ----------------------------------------------------------------------------
module io_peripheral_responder #(
    parameter int          DEB_TICK = 100000,
    parameter logic [23:0] LED_RST  = 24'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ioRead,
    input  logic        ioWrite,
    input  logic        LEDCtrl,
    input  logic        SwitchCtrl,
    input  logic [3:0]  addr,
    input  logic [15:0] write_data,
    input  logic [23:0] switch_in,
    output logic [15:0] io_rdata,
    output logic [23:0] led
);

    localparam int            TW        = (DEB_TICK > 1) ? $clog2(DEB_TICK) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DEB_TICK - 1);

    localparam logic [3:0] ADDR_LO  = 4'h0;
    localparam logic [3:0] ADDR_HI  = 4'h2;
    localparam logic [3:0] ADDR_CHG = 4'h4;

    logic [23:0]   sync1;
    logic [23:0]   sw_s;
    logic [23:0]   samp;
    logic [23:0]   sw_db;
    logic [23:0]   sw_db_next;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          chg;
    logic          chg_rd;
    logic          chg_rd_q;
    logic          chg_clr;
    logic          led_wr;

    assign led_wr = LEDCtrl & ioWrite;
    assign tick   = (tick_cnt == TICK_LAST);

    // A flag read only counts when the switch block actually owns the bus.
    // Only the first cycle of a (possibly multi-cycle) read clears the flag,
    // so a change that lands during a held read is not lost.
    assign chg_rd  = ioRead & SwitchCtrl & ~LEDCtrl & (addr == ADDR_CHG);
    assign chg_clr = chg_rd & ~chg_rd_q;

    // LED registers
    always_ff @(posedge clock) begin
        if (reset) begin
            led <= LED_RST;
        end else if (led_wr) begin
            case (addr)
                ADDR_LO: led[15:0]  <= write_data;
                ADDR_HI: led[23:16] <= write_data[7:0];
                default: ;
            endcase
        end
    end

    // A bit follows the synchronized pin only when the pin agrees with the
    // value captured on the previous tick, i.e. it was stable across two ticks.
    always_comb begin
        sw_db_next = sw_db;
        if (tick) begin
            sw_db_next = (sw_s & ~(sw_s ^ samp)) | (sw_db & (sw_s ^ samp));
        end
    end

    // Switch synchronizer, tick counter, debounce and change flag
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1    <= '0;
            sw_s     <= '0;
            samp     <= '0;
            sw_db    <= '0;
            tick_cnt <= '0;
            chg      <= 1'b0;
            chg_rd_q <= 1'b0;
        end else begin
            sync1    <= switch_in;
            sw_s     <= sync1;
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (tick) begin
                samp <= sw_s;
            end
            sw_db    <= sw_db_next;
            chg_rd_q <= chg_rd;
            // Set beats clear when both happen on the same edge.
            if (sw_db_next != sw_db) begin
                chg <= 1'b1;
            end else if (chg_clr) begin
                chg <= 1'b0;
            end
        end
    end

    // Read mux, LED select has priority over switch select
    always_comb begin
        io_rdata = 16'h0;
        if (ioRead && LEDCtrl) begin
            case (addr)
                ADDR_LO: io_rdata = led[15:0];
                ADDR_HI: io_rdata = {8'h0, led[23:16]};
                default: io_rdata = 16'h0;
            endcase
        end else if (ioRead && SwitchCtrl) begin
            case (addr)
                ADDR_LO:  io_rdata = sw_db[15:0];
                ADDR_HI:  io_rdata = {8'h0, sw_db[23:16]};
                ADDR_CHG: io_rdata = {15'h0, chg};
                default:  io_rdata = 16'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_peripheral_responder.sv
// ----------------------------------------------------------------------------
// tb_io_peripheral_responder
//   Table-driven vectors for the register map, hand-written sequences for the
//   debounce / read-to-clear / reset corner cases, then randomized traffic
//   checked against a behavioural model of the peripheral.
// ----------------------------------------------------------------------------
module tb_io_peripheral_responder;

  localparam int DEB = 4;

  logic        clock;
  logic        reset;
  logic        ioRead;
  logic        ioWrite;
  logic        LEDCtrl;
  logic        SwitchCtrl;
  logic [3:0]  addr;
  logic [15:0] write_data;
  logic [23:0] switch_in;
  logic [15:0] io_rdata;
  logic [23:0] led;

  int total = 0;
  int bad   = 0;

  io_peripheral_responder #(
    .DEB_TICK (DEB),
    .LED_RST  (24'h0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ioRead     (ioRead),
    .ioWrite    (ioWrite),
    .LEDCtrl    (LEDCtrl),
    .SwitchCtrl (SwitchCtrl),
    .addr       (addr),
    .write_data (write_data),
    .switch_in  (switch_in),
    .io_rdata   (io_rdata),
    .led        (led)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    reset = 1'b1; ioRead = 1'b0; ioWrite = 1'b0; LEDCtrl = 1'b0; SwitchCtrl = 1'b0;
    addr = 4'h0; write_data = 16'h0; switch_in = 24'h0;
  end

  // ---------------- behavioural reference model ----------------
  // Pins reach the debouncer two clocks late; a tick happens every DEB-th
  // clock since reset; a debounced bit takes the pin value only when that
  // value was also seen on the previous tick.
  int unsigned m_cyc;
  logic [23:0] m_led, m_samp, m_db;
  logic        m_chg, m_prev_rd;
  logic [23:0] pin_q[$];

  function automatic logic m_is_tick();
    return (m_cyc % DEB) == (DEB - 1);
  endfunction

  function automatic logic [23:0] m_db_next();
    logic [23:0] r;
    logic [23:0] seen;
    r = m_db;
    if (m_is_tick()) begin
      seen = pin_q[1];
      for (int i = 0; i < 24; i++) begin
        if (seen[i] == m_samp[i]) r[i] = seen[i];
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] exp_rdata();
    if (!ioRead) return 16'h0;
    if (LEDCtrl) begin
      if (addr == 4'h0) return m_led[15:0];
      if (addr == 4'h2) return {8'h0, m_led[23:16]};
      return 16'h0;
    end
    if (SwitchCtrl) begin
      if (addr == 4'h0) return m_db[15:0];
      if (addr == 4'h2) return {8'h0, m_db[23:16]};
      if (addr == 4'h4) return {15'h0, m_chg};
    end
    return 16'h0;
  endfunction

  always @(posedge clock) begin
    logic [23:0] nd;
    logic        rd_now;
    if (reset) begin
      m_led = 24'h0; m_samp = 24'h0; m_db = 24'h0; m_chg = 1'b0; m_prev_rd = 1'b0;
      m_cyc = 0;
      pin_q = '{24'h0, 24'h0};
    end else begin
      nd     = m_db_next();
      rd_now = ioRead && SwitchCtrl && !LEDCtrl && addr == 4'h4;
      if (nd != m_db) m_chg = 1'b1;
      else if (rd_now && !m_prev_rd) m_chg = 1'b0;
      m_prev_rd = rd_now;
      if (m_is_tick()) m_samp = pin_q[1];
      m_db = nd;
      pin_q.push_front(switch_in);
      void'(pin_q.pop_back());
      m_cyc++;
      if (LEDCtrl && ioWrite && addr == 4'h0) m_led[15:0]  = write_data;
      if (LEDCtrl && ioWrite && addr == 4'h2) m_led[23:16] = write_data[7:0];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input logic rst, input logic rd, input logic wr, input logic lc,
                            input logic sc, input logic [3:0] a, input logic [15:0] wd,
                            input logic [23:0] sw);
    reset = rst; ioRead = rd; ioWrite = wr; LEDCtrl = lc; SwitchCtrl = sc;
    addr = a; write_data = wd; switch_in = sw;
  endtask

  // Apply inputs on the falling edge, return 1 time unit later for sampling.
  task automatic drive(input logic rst, input logic rd, input logic wr, input logic lc,
                       input logic sc, input logic [3:0] a, input logic [15:0] wd,
                       input logic [23:0] sw);
    @(negedge clock);
    set_inputs(rst, rd, wr, lc, sc, a, wd, sw);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        rst, rd, wr, lc, sc;
    logic [3:0]  a;
    logic [15:0] wd;
    logic        chk_en;
    logic [15:0] exp_rd;
    logic [23:0] exp_led;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input string name, input logic rst, input logic rd, input logic wr,
                         input logic lc, input logic sc, input logic [3:0] a,
                         input logic [15:0] wd, input logic chk_en,
                         input logic [15:0] exp_rd, input logic [23:0] exp_led);
    vec_t v;
    v.name = name; v.rst = rst; v.rd = rd; v.wr = wr; v.lc = lc; v.sc = sc;
    v.a = a; v.wd = wd; v.chk_en = chk_en; v.exp_rd = exp_rd; v.exp_led = exp_led;
    vq.push_back(v);
  endtask

  // ---------------- main test ----------------
  initial begin
    logic        found;
    logic        hit;
    logic [23:0] sw_cur;
    logic [23:0] sw_app;
    logic [3:0]  ra;
    int          pick;

    //          name            rst rd wr lc sc addr   wd       chk exp_rd    exp_led
    add_vec("rst_hold0",       1, 0, 0, 0, 0, 4'h0, 16'h0,    0, 16'h0,    24'h0);
    add_vec("rst_led",         1, 0, 0, 0, 0, 4'h0, 16'h0,    1, 16'h0,    24'h0);
    add_vec("rst_sw_lo",       0, 1, 0, 0, 1, 4'h0, 16'h0,    1, 16'h0,    24'h0);
    add_vec("rst_chg",         0, 1, 0, 0, 1, 4'h4, 16'h0,    1, 16'h0,    24'h0);
    add_vec("wr_hi",           0, 0, 1, 1, 0, 4'h2, 16'hABCD, 1, 16'h0,    24'h0);
    add_vec("wr_lo",           0, 0, 1, 1, 0, 4'h0, 16'h1234, 1, 16'h0,    24'hCD0000);
    add_vec("rd_led_hi",       0, 1, 0, 1, 0, 4'h2, 16'h0,    1, 16'h00CD, 24'hCD1234);
    add_vec("rd_led_lo",       0, 1, 0, 1, 0, 4'h0, 16'h0,    1, 16'h1234, 24'hCD1234);
    add_vec("wr_unmapped",     0, 0, 1, 1, 0, 4'h6, 16'hFFFF, 1, 16'h0,    24'hCD1234);
    add_vec("wr_switch_sel",   0, 0, 1, 0, 1, 4'h0, 16'h5555, 1, 16'h0,    24'hCD1234);
    add_vec("rd_no_cs",        0, 1, 0, 0, 0, 4'h0, 16'h0,    1, 16'h0,    24'hCD1234);
    add_vec("rd_led_unmapped", 0, 1, 0, 1, 0, 4'h6, 16'h0,    1, 16'h0,    24'hCD1234);
    add_vec("rd_both_cs",      0, 1, 0, 1, 1, 4'h0, 16'h0,    1, 16'h1234, 24'hCD1234);
    add_vec("idle",            0, 0, 0, 0, 0, 4'h0, 16'h0,    1, 16'h0,    24'hCD1234);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].rd, vq[i].wr, vq[i].lc, vq[i].sc, vq[i].a, vq[i].wd, 24'h0);
      if (vq[i].chk_en) begin
        chk({vq[i].name, "_rdata"}, io_rdata, vq[i].exp_rd);
        chk({vq[i].name, "_led"}, led, vq[i].exp_led);
      end
    end

    // Debounce: bit 0 held high must appear within 2 sync cycles + 2 ticks.
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      drive(0, 1, 0, 0, 1, 4'h0, 16'h0, 24'h000001);
      if (io_rdata == 16'h0001) found = 1'b1;
    end
    chk("deb_bit0_seen", found, 1'b1);

    // Read-to-clear held for 3 cycles: 1, then 0, 0.
    drive(0, 1, 0, 0, 1, 4'h4, 16'h0, 24'h000001);
    chk("chg_rd1", io_rdata, 16'h0001);
    drive(0, 1, 0, 0, 1, 4'h4, 16'h0, 24'h000001);
    chk("chg_rd2", io_rdata, 16'h0000);
    drive(0, 1, 0, 0, 1, 4'h4, 16'h0, 24'h000001);
    chk("chg_rd3", io_rdata, 16'h0000);

    // One-cycle glitch on bit 5 must not reach the debounced value.
    drive(0, 0, 0, 0, 0, 4'h0, 16'h0, 24'h000021);
    for (int i = 0; i < 12; i++) drive(0, 0, 0, 0, 0, 4'h0, 16'h0, 24'h000001);
    drive(0, 1, 0, 0, 1, 4'h0, 16'h0, 24'h000001);
    chk("glitch_db", io_rdata, 16'h0001);
    drive(0, 1, 0, 0, 1, 4'h4, 16'h0, 24'h000001);
    chk("glitch_chg", io_rdata, 16'h0000);
    drive(0, 0, 0, 0, 0, 4'h0, 16'h0, 24'h000001);

    // A fresh flag read landing on the same edge as a debounced change: set wins.
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clock);
      if (m_db_next() != m_db) begin
        set_inputs(0, 1, 0, 0, 1, 4'h4, 16'h0, 24'h000003);
        hit = 1'b1;
        #1;
        chk("setclr_rd", io_rdata, 16'h0000);
      end else begin
        set_inputs(0, 0, 0, 0, 0, 4'h0, 16'h0, 24'h000003);
      end
    end
    chk("setclr_edge_found", hit, 1'b1);
    drive(0, 0, 0, 0, 0, 4'h0, 16'h0, 24'h000003);
    drive(0, 1, 0, 0, 1, 4'h4, 16'h0, 24'h000003);
    chk("setclr_kept", io_rdata, 16'h0001);
    drive(0, 1, 0, 0, 1, 4'h4, 16'h0, 24'h000003);
    chk("setclr_cleared", io_rdata, 16'h0000);
    drive(0, 1, 0, 0, 1, 4'h0, 16'h0, 24'h000003);
    chk("setclr_db", io_rdata, 16'h0003);

    // Reset mid-debounce: partial samples are discarded.
    drive(1, 0, 0, 0, 0, 4'h0, 16'h0, 24'h0);
    drive(1, 0, 0, 0, 0, 4'h0, 16'h0, 24'h0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 4'h0, 16'h0, 24'hFFFFFF);
    drive(1, 0, 0, 0, 0, 4'h0, 16'h0, 24'hFFFFFF);
    drive(0, 1, 0, 0, 1, 4'h0, 16'h0, 24'hFFFFFF);
    chk("midrst_db_lo", io_rdata, 16'h0000);
    chk("midrst_led", led, 24'h0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      drive(0, 1, 0, 0, 1, 4'h0, 16'h0, 24'hFFFFFF);
      if (io_rdata == 16'hFFFF) found = 1'b1;
    end
    chk("midrst_db_back", found, 1'b1);
    drive(0, 1, 0, 0, 1, 4'h2, 16'h0, 24'hFFFFFF);
    chk("midrst_db_hi", io_rdata, 16'h00FF);

    // Randomized traffic against the model.
    sw_cur = 24'hFFFFFF;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) sw_cur = 24'($urandom);
      sw_app = sw_cur;
      if ($urandom_range(0, 19) == 0) sw_app = sw_cur ^ (24'd1 << $urandom_range(0, 23));
      pick = int'($urandom_range(0, 4));
      case (pick)
        0: ra = 4'h0;
        1: ra = 4'h2;
        2: ra = 4'h4;
        3: ra = 4'h6;
        default: ra = 4'($urandom_range(0, 15));
      endcase
      drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0), ra,
            16'($urandom), sw_app);
      chk("rand_rdata", io_rdata, exp_rdata());
      chk("rand_led", led, m_led);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
